// File: rtl/risc_boot_ctrl.sv
// risc_boot_ctrl: program loader and run controller for the 16-bit RISC core.
// A session streams (addr,data) beats into CPU RAM while summing the data words.
// It then checks that sum against the host's expected checksum. On a match the
// CPU runs until it reports done or the watchdog expires. Independently of the
// session, every rising edge of the CPU output strobe is captured into a small FIFO.
module risc_boot_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int CNT_W       = 16,
    parameter int TO_W        = 32,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int OUT_DEPTH   = 8
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [DATA_W-1:0] s_csum,
    output logic [ADDR_W-1:0] Ram_addr,
    output logic [DATA_W-1:0] Ram_data,
    output logic              WR_RAM_E,
    output logic              E,
    input  logic              done,
    input  logic              out_flag,
    input  logic [DATA_W-1:0] out_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              o_ready,
    output logic [CNT_W-1:0]  inst_count,
    output logic              busy,
    output logic [1:0]        status,
    output logic              ovf
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(OUT_DEPTH);

    localparam logic [1:0] STAT_NONE = 2'd0;
    localparam logic [1:0] STAT_PASS = 2'd1;
    localparam logic [1:0] STAT_CSUM = 2'd2;
    localparam logic [1:0] STAT_TOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RUN,
        ST_FIN
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_status;
    logic [1:0]         w_status_next;

    logic [ADDR_W-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_data;
    logic               r_wr_e;
    logic [CNT_W-1:0]   r_inst_count;
    logic [DATA_W-1:0]  r_csum;
    logic [DATA_W-1:0]  r_csum_exp;
    logic [TO_W-1:0]    r_wd;

    logic               r_flag_q;
    logic [DATA_W-1:0]  r_mem [OUT_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_ovf;

    logic               w_accept;
    logic               w_start_ok;
    logic               w_timeout;
    logic               w_rise;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    // A new session may only be opened from a quiescent state.
    assign w_start_ok = start & ((r_state == ST_IDLE) | (r_state == ST_FIN));
    assign w_accept   = s_valid & s_ready;
    assign w_timeout  = (r_state == ST_RUN) & (r_wd == TO_LAST);

    assign s_ready    = (r_state == ST_LOAD);
    assign E          = (r_state == ST_RUN);
    assign busy       = (r_state == ST_LOAD) | (r_state == ST_CHECK) | (r_state == ST_RUN);
    assign status     = r_status;
    assign ovf        = r_ovf;
    assign Ram_addr   = r_ram_addr;
    assign Ram_data   = r_ram_data;
    assign WR_RAM_E   = r_wr_e;
    assign inst_count = r_inst_count;

    // FIFO occupancy; a pop on an empty FIFO is simply not possible.
    assign w_rise  = out_flag & ~r_flag_q;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FIFO_FULL);
    assign w_pop   = o_ready & ~w_empty;
    assign w_push  = w_rise & (~w_full | w_pop);
    assign o_valid = ~w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];

    // State and session status register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_status <= STAT_NONE;
        end else begin
            r_state  <= w_state_next;
            r_status <= w_status_next;
        end
    end

    // Next-state and status decisions; done has priority over the watchdog.
    always_comb begin
        w_state_next  = r_state;
        w_status_next = r_status;
        case (r_state)
            ST_IDLE, ST_FIN: begin
                if (start) begin
                    w_state_next  = ST_LOAD;
                    w_status_next = STAT_NONE;
                end
            end
            ST_LOAD: begin
                if (w_accept && s_last) begin
                    w_state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_csum == r_csum_exp) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next  = ST_FIN;
                    w_status_next = STAT_CSUM;
                end
            end
            ST_RUN: begin
                if (done) begin
                    w_state_next  = ST_FIN;
                    w_status_next = STAT_PASS;
                end else if (w_timeout) begin
                    w_state_next  = ST_FIN;
                    w_status_next = STAT_TOUT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Load path: register each accepted beat toward RAM and accumulate the count and checksum.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
            r_wr_e       <= 1'b0;
            r_inst_count <= '0;
            r_csum       <= '0;
            r_csum_exp   <= '0;
        end else begin
            r_wr_e <= w_accept;
            if (w_accept) begin
                r_ram_addr   <= s_addr;
                r_ram_data   <= s_data;
                r_inst_count <= r_inst_count + CNT_W'(1);
                r_csum       <= r_csum + s_data;
                if (s_last) begin
                    r_csum_exp <= s_csum;
                end
            end else if (w_start_ok) begin
                r_inst_count <= '0;
                r_csum       <= '0;
            end
        end
    end

    // Watchdog: zeroed during the check cycle so the first RUN cycle reads 0.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= '0;
        end else if (r_state == ST_CHECK) begin
            r_wd <= '0;
        end else if (r_state == ST_RUN) begin
            r_wd <= r_wd + TO_W'(1);
        end
    end

    // Capture control: edge detector, pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_q <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_flag_q <= out_flag;
            if (w_start_ok) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + (PTR_W + 1)'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - (PTR_W + 1)'(1);
                end
                if (w_rise && w_full && !w_pop) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge CLK) begin
        if (w_push && !w_start_ok) begin
            r_mem[r_wr_ptr] <= out_data;
        end
    end

endmodule

// File: tb/tb_risc_boot_ctrl.sv
// Bench for risc_boot_ctrl: directed scenarios plus randomized sessions,
// checked every cycle against a behavioural model of a load/run session.
module tb_risc_boot_ctrl;

    localparam int TO    = 20;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        done = 1'b0;
    logic        out_flag = 1'b0;
    logic        o_ready = 1'b0;
    logic [15:0] s_addr = '0;
    logic [15:0] s_data = '0;
    logic [15:0] s_csum = '0;
    logic [15:0] out_data = '0;

    logic        s_ready, WR_RAM_E, E, o_valid, busy, ovf;
    logic [15:0] Ram_addr, Ram_data, o_data, inst_count;
    logic [1:0]  status;

    risc_boot_ctrl #(
        .DATA_W(16), .ADDR_W(16), .CNT_W(16), .TO_W(32),
        .TIMEOUT_CYC(TO), .OUT_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
        .s_last(s_last), .s_csum(s_csum),
        .Ram_addr(Ram_addr), .Ram_data(Ram_data), .WR_RAM_E(WR_RAM_E),
        .E(E), .done(done), .out_flag(out_flag), .out_data(out_data),
        .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
        .inst_count(inst_count), .busy(busy), .status(status), .ovf(ovf)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of a session ----------------
    localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_RUN = 3, P_FIN = 4;
    int          ph;
    int          run_cyc;
    bit          m_wr;
    logic [15:0] m_addr, m_data, m_cnt, m_sum, m_exp;
    int          m_status;
    bit          m_ovf;
    bit          m_fprev;
    logic [15:0] m_q[$];

    task automatic model_reset();
        ph = P_IDLE; run_cyc = 0; m_wr = 0; m_addr = 0; m_data = 0; m_cnt = 0;
        m_sum = 0; m_exp = 0; m_status = 0; m_ovf = 0; m_fprev = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit rise, pop, st;
        rise = out_flag && !m_fprev;
        m_fprev = out_flag;
        st  = start && (ph == P_IDLE || ph == P_FIN);
        pop = o_ready && (m_q.size() > 0);
        if (st) begin
            m_q.delete();
            m_ovf = 0;
        end else begin
            if (pop) m_q.delete(0);
            if (rise) begin
                if (m_q.size() < DEPTH) m_q.push_back(out_data);
                else m_ovf = 1;
            end
        end
        m_wr = 0;
        case (ph)
            P_IDLE, P_FIN: if (start) begin
                ph = P_LOAD; m_cnt = 0; m_sum = 0; m_status = 0;
            end
            P_LOAD: if (s_valid) begin
                m_wr = 1; m_addr = s_addr; m_data = s_data;
                m_cnt = m_cnt + 16'd1; m_sum = m_sum + s_data;
                if (s_last) begin m_exp = s_csum; ph = P_CHECK; end
            end
            P_CHECK: if (m_sum == m_exp) begin ph = P_RUN; run_cyc = 0; end
                     else begin ph = P_FIN; m_status = 2; end
            P_RUN: begin
                run_cyc++;
                if (done) begin ph = P_FIN; m_status = 1; end
                else if (run_cyc == TO) begin ph = P_FIN; m_status = 3; end
            end
            default: ph = P_IDLE;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    int          e_cycles = 0;
    logic [31:0] wr_log[$];

    initial forever begin
        @(posedge CLK);
        #1;
        if (rst_n) begin
            chk("s_ready", 32'(s_ready), 32'(ph == P_LOAD));
            chk("E", 32'(E), 32'(ph == P_RUN));
            chk("busy", 32'(busy), 32'(ph == P_LOAD || ph == P_CHECK || ph == P_RUN));
            chk("WR_RAM_E", 32'(WR_RAM_E), 32'(m_wr));
            chk("Ram_addr", 32'(Ram_addr), 32'(m_addr));
            chk("Ram_data", 32'(Ram_data), 32'(m_data));
            chk("inst_count", 32'(inst_count), 32'(m_cnt));
            chk("status", 32'(status), 32'(m_status));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("o_valid", 32'(o_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) chk("o_data", 32'(o_data), 32'(m_q[0]));
            if (E) e_cycles++;
            if (WR_RAM_E) wr_log.push_back({Ram_addr, Ram_data});
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rnd_io = 0;

    initial forever begin
        @(negedge CLK);
        if (rnd_io) begin
            out_flag = ($urandom_range(0, 2) == 0);
            out_data = 16'($urandom);
            o_ready  = 1'($urandom_range(0, 1));
        end
    end

    task automatic clear_obs();
        e_cycles = 0;
        wr_log.delete();
    endtask

    task automatic pulse_start();
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
    endtask

    // Drives one beat at the current negedge, held for one cycle.
    task automatic beat(input logic [15:0] a, input logic [15:0] d, input bit last, input logic [15:0] cs);
        s_valid = 1'b1; s_addr = a; s_data = d; s_last = last; s_csum = cs;
        @(negedge CLK);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic load_rand(input int n, input bit good);
        logic [15:0] sum;
        logic [15:0] d;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            d = 16'($urandom);
            sum = sum + d;
            beat(16'($urandom), d, i == n - 1, (i == n - 1) ? (good ? sum : sum + 16'd1) : 16'($urandom));
        end
    endtask

    task automatic wait_e();
        for (int i = 0; i < 20; i++) begin
            if (E) break;
            @(negedge CLK);
        end
        chk("E_rise", 32'(E), 32'd1);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (!busy) break;
            @(negedge CLK);
        end
        chk("session_end", 32'(busy), 32'd0);
    endtask

    task automatic run_session(input int n, input bit good, input int dly);
        pulse_start();
        load_rand(n, good);
        if (good) begin
            wait_e();
            for (int i = 0; i < dly; i++) begin
                if (!busy) break;
                @(negedge CLK);
            end
            if (busy) begin
                done = 1'b1; @(negedge CLK); done = 1'b0;
            end
        end
        wait_idle(60);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_E", 32'(E), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_wr", 32'(WR_RAM_E), 0);
        chk("rst_o_valid", 32'(o_valid), 0);
        chk("rst_inst_count", 32'(inst_count), 0);
        rst_n = 1'b1;

        // 1: good load of three words, then done
        clear_obs();
        pulse_start();
        beat(16'd0, 16'h1111, 0, 16'h0);
        beat(16'd1, 16'h2222, 0, 16'h0);
        beat(16'd2, 16'h3333, 1, 16'h6666);
        wait_e();
        chk("t1_inst_count", 32'(inst_count), 3);
        done = 1'b1; @(negedge CLK); done = 1'b0;
        chk("t1_status", 32'(status), 1);
        chk("t1_E_low", 32'(E), 0);
        chk("t1_writes", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            chk("t1_w0", wr_log[0], 32'h0000_1111);
            chk("t1_w1", wr_log[1], 32'h0001_2222);
            chk("t1_w2", wr_log[2], 32'h0002_3333);
        end

        // 2: checksum mismatch
        clear_obs();
        pulse_start();
        beat(16'd0, 16'h1111, 0, 16'h0);
        beat(16'd1, 16'h2222, 0, 16'h0);
        beat(16'd2, 16'h3333, 1, 16'h6667);
        wait_idle(10);
        chk("t2_status", 32'(status), 2);
        chk("t2_E_never", e_cycles, 0);
        chk("t2_busy", 32'(busy), 0);

        // 3: timeout after exactly TO run cycles
        clear_obs();
        pulse_start();
        load_rand(3, 1);
        wait_e();
        wait_idle(60);
        chk("t3_E_cycles", e_cycles, 20);
        chk("t3_status", 32'(status), 3);

        // 4: overflow of the output FIFO, then ordered drain
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK); out_flag = 1'b1; out_data = 16'(k);
            @(negedge CLK); out_flag = 1'b0;
        end
        @(negedge CLK);
        chk("t4_ovf", 32'(ovf), 1);
        for (int k = 1; k <= 4; k++) begin
            chk("t4_pop", 32'(o_data), 32'(k));
            o_ready = 1'b1;
            @(negedge CLK);
        end
        o_ready = 1'b0;
        chk("t4_empty", 32'(o_valid), 0);
        chk("t4_ovf_sticky", 32'(ovf), 1);

        // 5: asynchronous reset in the middle of a load
        pulse_start();
        beat(16'h10, 16'hABCD, 0, 16'h0);
        beat(16'h11, 16'h1234, 0, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_E", 32'(E), 0);
        chk("t5_wr", 32'(WR_RAM_E), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_inst_count", 32'(inst_count), 0);
        @(negedge CLK); rst_n = 1'b1;
        clear_obs();
        run_session(4, 1, 3);
        chk("t5_reload_status", 32'(status), 1);
        chk("t5_reload_count", 32'(inst_count), 4);

        // 6: gaps, ignored start in RUN, done together with timeout
        clear_obs();
        pulse_start();
        load_rand(4, 1);
        wait_e();
        repeat (4) @(negedge CLK);
        start = 1'b1; @(negedge CLK); start = 1'b0;
        repeat (14) @(negedge CLK);
        done = 1'b1; @(negedge CLK); done = 1'b0;
        chk("t6_status", 32'(status), 1);
        chk("t6_E_cycles", e_cycles, 20);
        chk("t6_writes", wr_log.size(), 4);

        // randomized sessions with random capture traffic
        rnd_io = 1;
        for (int s = 0; s < 30; s++) begin
            run_session($urandom_range(1, 6), $urandom_range(0, 3) != 0, $urandom_range(0, 24));
            repeat ($urandom_range(0, 4)) @(negedge CLK);
        end
        rnd_io = 0;
        @(negedge CLK);
        out_flag = 1'b0; o_ready = 1'b0;
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
